ha_response_checker: RTL and testbench

- Sequential checker on the response side of the half_adder stimulus flow: samples each applied vector {a,b} and the DUT response {sum,carry} on a strobe.
- Compares each response against the golden half-adder result and keeps vector and error counts.
- Captures the first failing vector and declares pass/fail after a programmed number of vectors.
- Sits beside half_adder in benches and on-board self-test wrappers; replaces manual waveform inspection.

---
 rtl/ha_response_checker.sv | 96 +++++++++
 tb/tb_ha_response_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ha_response_checker.sv
// Response-side checker for half_adder: compares each strobed {sum,carry} against
// the golden a^b / a&b result, counts vectors and mismatches, and latches the first failure.
module ha_response_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       first_fail,
  output logic [CNT_W-1:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic             mismatch;
  logic [CNT_W-1:0] vec_next;

  assign mismatch = (sum != (a ^ b)) | (carry != (a & b));
  assign vec_next = vec_cnt + ONE;

  // The run ends on the accept that brings vec_cnt to NUM_VEC, so pass must
  // account for a mismatch on that very vector, not just the errors before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_flag       <= 1'b0;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_flag       <= 1'b0;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_idx <= '0;
          end
        end
        RUN: begin
          if (sample_valid) begin
            vec_cnt <= vec_next;
            if (mismatch) begin
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ONE;
              end
              err_flag <= 1'b1;
              if (!err_flag) begin
                first_fail     <= {a, b, sum, carry};
                first_fail_idx <= vec_cnt;
              end
            end
            if (vec_next == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !(err_flag || mismatch);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_response_checker.sv
// Bench for ha_response_checker: a queue-based model of each run is compared every
// cycle, plus fixed expectations for the directed scenarios.
module tb_ha_response_checker;

  localparam int NUM_VEC = 4;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sample_valid;
  logic             a;
  logic             b;
  logic             sum;
  logic             carry;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_flag;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       first_fail;
  logic [CNT_W-1:0] first_fail_idx;

  int checks = 0;
  int errors = 0;

  bit         m_running = 1'b0;
  bit         m_finished = 1'b0;
  logic [3:0] m_acc[$];

  ha_response_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sample_valid(sample_valid),
    .a(a),
    .b(b),
    .sum(sum),
    .carry(carry),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_flag(err_flag),
    .vec_cnt(vec_cnt),
    .err_cnt(err_cnt),
    .first_fail(first_fail),
    .first_fail_idx(first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [3:0] v, input logic st);
    start        = st;
    sample_valid = sv;
    {a, b, sum, carry} = v;
    @(posedge clk);
    #1;
  endtask

  // {a,b,sum,carry} is wrong when {carry,sum} differs from the arithmetic sum a+b
  function automatic bit isBad(input logic [3:0] v);
    int total;
    total = int'(v[3]) + int'(v[2]);
    return (int'(v[1]) != total % 2) || (int'(v[0]) != total / 2);
  endfunction

  function automatic logic [3:0] randVec(input bit good);
    logic va, vb;
    logic [1:0] resp;
    va   = 1'($urandom_range(0, 1));
    vb   = 1'($urandom_range(0, 1));
    resp = good ? {va ^ vb, va & vb} : 2'($urandom_range(0, 3));
    return {va, vb, resp};
  endfunction

  // Reference model: a run is just the list of vectors accepted since the last start
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_running  = 1'b0;
        m_finished = 1'b0;
        m_acc.delete();
      end else if (!m_running) begin
        if (start) begin
          m_running  = 1'b1;
          m_finished = 1'b0;
          m_acc.delete();
        end
      end else if (sample_valid) begin
        m_acc.push_back({a, b, sum, carry});
        if (m_acc.size() == NUM_VEC) begin
          m_running  = 1'b0;
          m_finished = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      int errs;
      int first;
      logic [3:0] ffv;
      @(negedge clk);
      errs  = 0;
      first = -1;
      ffv   = '0;
      foreach (m_acc[i]) begin
        if (isBad(m_acc[i])) begin
          if (first < 0) begin
            first = i;
            ffv   = m_acc[i];
          end
          errs++;
        end
      end
      checkOutput("busy", 32'(busy), 32'(m_running));
      checkOutput("done", 32'(done), 32'(m_finished));
      checkOutput("pass", 32'(pass), 32'(m_finished && errs == 0));
      checkOutput("err_flag", 32'(err_flag), 32'(errs > 0));
      checkOutput("vec_cnt", 32'(vec_cnt), 32'(m_acc.size()));
      checkOutput("err_cnt", 32'(err_cnt), 32'((errs > 255) ? 255 : errs));
      checkOutput("first_fail", 32'(first_fail), 32'(ffv));
      checkOutput("first_fail_idx", 32'(first_fail_idx), 32'((first < 0) ? 0 : first));
    end
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    sample_valid = 1'b0;
    {a, b, sum, carry} = 4'b0000;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset vec_cnt", 32'(vec_cnt), 32'd0);

    // strobes while idle are ignored
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    checkOutput("idle vec_cnt", 32'(vec_cnt), 32'd0);

    // good run
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b1010, 1'b0);
    checkOutput("good done early", 32'(done), 32'd0);
    applyStimulus(1'b1, 4'b1101, 1'b0);
    checkOutput("good vec_cnt", 32'(vec_cnt), 32'd4);
    checkOutput("good done", 32'(done), 32'd1);
    checkOutput("good pass", 32'(pass), 32'd1);
    checkOutput("good err_flag", 32'(err_flag), 32'd0);

    // faulty responses on the 3rd and 4th vectors
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("faulty err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("faulty err_flag", 32'(err_flag), 32'd1);
    checkOutput("faulty first_fail", 32'(first_fail), 32'b1000);
    checkOutput("faulty first_fail_idx", 32'(first_fail_idx), 32'd2);
    checkOutput("faulty pass", 32'(pass), 32'd0);

    // restart from DONE
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("restart vec_cnt", 32'(vec_cnt), 32'd0);
    checkOutput("restart err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("restart err_flag", 32'(err_flag), 32'd0);
    checkOutput("restart done", 32'(done), 32'd0);
    checkOutput("restart busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b1101, 1'b0);
    applyStimulus(1'b1, 4'b1010, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("restart pass", 32'(pass), 32'd1);

    // gapped strobes, strobes in DONE, start coinciding with valid, start mid-run
    applyStimulus(1'b1, 4'b0111, 1'b0);
    applyStimulus(1'b1, 4'b0111, 1'b1);
    checkOutput("gap start vec_cnt", 32'(vec_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, randVec(1'b0), 1'b0);
      applyStimulus(1'b1, randVec(i != 1), 1'b0);
      if (i == 1) applyStimulus(1'b0, 4'b0000, 1'b1);
    end
    checkOutput("gap vec_cnt", 32'(vec_cnt), 32'd4);
    checkOutput("gap done", 32'(done), 32'd1);
    repeat (2) applyStimulus(1'b1, randVec(1'b0), 1'b0);
    checkOutput("done hold vec_cnt", 32'(vec_cnt), 32'd4);

    // reset mid-run, between edges
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async vec_cnt", 32'(vec_cnt), 32'd0);
    checkOutput("async err_flag", 32'(err_flag), 32'd0);
    checkOutput("async first_fail", 32'(first_fail), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b1);
    repeat (4) applyStimulus(1'b1, randVec(1'b1), 1'b0);
    checkOutput("post-reset done", 32'(done), 32'd1);
    checkOutput("post-reset pass", 32'(pass), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), randVec($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
